store_buffer: RTL and testbench

// - Write buffer between the byte-lane store formatter and data-BRAM port B.
// - Queues formatted stores {word addr, byte enables, lane data} and retires them to

---
 rtl/store_buffer.sv | 142 ++++++++++++++
 tb/tb_store_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the store formatter and data-BRAM port B.
// Loads own the port; queued stores retire when it is idle, or are forced out after
// MAX_DEFER consecutive deferred cycles. Pending entries are compared against each load
// to raise ld_hazard for read-after-write conflicts.
// Build option: define STORE_BUFFER_FWD_EN to add store-to-load forwarding
// (fwd_data/fwd_mask); without it any overlapping pending store stalls the load.
module store_buffer #(
   parameter int DEPTH     = 4,
   parameter int MAX_DEFER = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [3:0]               st_web,
   input  logic [31:0]              st_dib,
   output logic                     st_ready,
   input  logic                     ld_req,
   input  logic [31:0]              ld_addr,
   input  logic [3:0]               ld_mask,
   output logic                     ld_hazard,
   output logic                     mem_en,
   output logic [3:0]               mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_di,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
`ifdef STORE_BUFFER_FWD_EN
   ,
   output logic [31:0]              fwd_data,
   output logic [3:0]               fwd_mask
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = $clog2(MAX_DEFER + 1);

   logic [29:0]   ent_addr [DEPTH];
   logic [3:0]    ent_web  [DEPTH];
   logic [31:0]   ent_dib  [DEPTH];
   logic [DEPTH-1:0] ent_vld;

   logic [PW-1:0] head, tail;
   logic [DW-1:0] defer;
   logic [CW-1:0] count_nxt;
   logic          push, pop, forced;
   logic [DEPTH-1:0] match;
   logic          hazard_cond;

   // Byte-offset bits are meaningless here: stores arrive lane-shifted, loads compare words.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

   assign st_ready = !full;
   assign push     = st_valid && st_ready && (st_web != 4'b0000);
   assign forced   = (defer == DW'(MAX_DEFER));
   assign mem_en   = !empty && (!ld_req || forced);
   assign pop      = mem_en;
   assign count_nxt = count + CW'(push) - CW'(pop);

   // Head entry presented to the BRAM; byte enables gated so an idle port never writes.
   always_comb begin
      mem_we   = mem_en ? ent_web[head] : 4'b0000;
      mem_addr = {ent_addr[head], 2'b00};
      mem_di   = ent_dib[head];
   end

   // Pointer, occupancy, valid and defer-counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         defer   <= '0;
         ent_vld <= '0;
      end else begin
         if (push) begin
            tail          <= tail + 1'b1;
            ent_vld[tail] <= 1'b1;
         end
         if (pop) begin
            head          <= head + 1'b1;
            ent_vld[head] <= 1'b0;
         end
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CW'(DEPTH));
         if (mem_en || empty)
            defer <= '0;
         else if (ld_req && !forced)
            defer <= defer + 1'b1;
      end
   end

   // Entry payload; needs no reset because ent_vld qualifies every use.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[tail] <= st_addr[31:2];
         ent_web[tail]  <= st_web;
         ent_dib[tail]  <= st_dib;
      end
   end

   // Word-and-lane overlap of each pending entry with the current load.
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++)
         match[i] = ent_vld[i] && (ent_addr[i] == ld_addr[31:2]) &&
                    ((ent_web[i] & ld_mask) != 4'b0000);
   end

`ifdef STORE_BUFFER_FWD_EN
   logic [PW-1:0] fwd_idx;

   // Overlay matching entries oldest to youngest so the newest byte per lane wins.
   always_comb begin
      fwd_data = '0;
      fwd_mask = '0;
      fwd_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head + PW'(k);
         if (match[fwd_idx]) begin
            for (int b = 0; b < 4; b++)
               if (ent_web[fwd_idx][b])
                  fwd_data[8*b +: 8] = ent_dib[fwd_idx][8*b +: 8];
            fwd_mask = fwd_mask | ent_web[fwd_idx];
         end
      end
   end

   assign hazard_cond = (match != '0) && ((ld_mask & ~fwd_mask) != 4'b0000);
`else
   assign hazard_cond = (match != '0);
`endif

   assign ld_hazard = ld_req && (forced || hazard_cond);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4, MAX_DEFER=8); covers both builds of
// STORE_BUFFER_FWD_EN.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [3:0]  st_web;
   logic [31:0] st_dib;
   logic        st_ready;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [3:0]  ld_mask;
   logic        ld_hazard;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_di;
   logic [2:0]  count;
   logic        empty;
   logic        full;
`ifdef STORE_BUFFER_FWD_EN
   logic [31:0] fwd_data;
   logic [3:0]  fwd_mask;
`endif

   int n_chk = 0;
   int n_err = 0;
   int nzero;
   int writes;
   logic seen;

   store_buffer #(.DEPTH(4), .MAX_DEFER(8)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_addr(st_addr), .st_web(st_web), .st_dib(st_dib),
      .st_ready(st_ready),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_hazard(ld_hazard),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
      .count(count), .empty(empty), .full(full)
`ifdef STORE_BUFFER_FWD_EN
      , .fwd_data(fwd_data), .fwd_mask(fwd_mask)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      st_valid = 1'b1;
      st_addr  = a;
      st_web   = w;
      st_dib   = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_web = '0; st_dib = '0;
      ld_req = 1'b0; ld_addr = '0; ld_mask = '0;
      step; step;
      rst = 1'b0;
      settle;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ready", st_ready, 1);
      chk("rst_mem_en", mem_en, 0);

      // single word store drains the next cycle when no load competes
      store(32'h100, 4'b1111, 32'hDEADBEEF);
      settle;
      chk("sw_no_early_write", mem_en, 0);
      step;
      st_valid = 1'b0;
      settle;
      chk("sw_mem_en", mem_en, 1);
      chk("sw_mem_addr", mem_addr, 32'h100);
      chk("sw_mem_we", mem_we, 4'b1111);
      chk("sw_mem_di", mem_di, 32'hDEADBEEF);
      chk("sw_count1", count, 1);
      step; settle;
      chk("sw_count0", count, 0);
      chk("sw_empty", empty, 1);
      chk("sw_idle_we", mem_we, 0);

      // loads hold the port: 8 deferred cycles, then a forced drain
      ld_req = 1'b1; ld_addr = 32'h800; ld_mask = 4'b1111;
      store(32'h10, 4'b1111, 32'hA0);
      step;
      nzero = 0;
      seen  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (c < 3) store(32'h14 + 32'(4 * c), 4'b1111, 32'hA1 + 32'(c));
         else if (c == 3) store(32'h50, 4'b1111, 32'hBAD);
         else st_valid = 1'b0;
         settle;
         if (c == 0) chk("defer_no_hazard", ld_hazard, 0);
         if (c == 3) begin
            chk("defer_full", full, 1);
            chk("defer_not_ready", st_ready, 0);
         end
         if (c == 4) chk("defer_fifth_held", count, 4);
         if (mem_en) begin
            seen = 1'b1;
            chk("forced_hazard", ld_hazard, 1);
            chk("forced_count", count, 4);
            chk("forced_addr", mem_addr, 32'h10);
            break;
         end
         nzero++;
         step;
      end
      st_valid = 1'b0;
      chk("forced_seen", seen, 1);
      chk("deferred_cycles", nzero, 8);
      step; settle;
      chk("forced_count3", count, 3);
      chk("post_forced_defer", mem_en, 0);

      // refill, then reset while draining
      store(32'h60, 4'b1111, 32'hC0);
      step;
      st_valid = 1'b0; ld_req = 1'b0;
      settle;
      chk("rstmid_full", full, 1);
      chk("rstmid_draining", mem_en, 1);
      chk("rstmid_head", mem_addr, 32'h14);
      rst = 1'b1;
      step;
      rst = 1'b0;
      settle;
      chk("rstmid_count", count, 0);
      chk("rstmid_empty", empty, 1);
      chk("rstmid_full0", full, 0);
      chk("rstmid_mem_en", mem_en, 0);
      writes = 0;
      for (int c = 0; c < 5; c++) begin
         if (mem_en) writes++;
         step;
      end
      chk("rstmid_no_writes", writes, 0);

      // byte store then overlapping byte load
      ld_req = 1'b1; ld_addr = 32'h204; ld_mask = 4'b0010;
      store(32'h204, 4'b0010, 32'h0000AB00);
      settle;
      chk("sb_same_cycle", ld_hazard, 0);
      step;
      st_valid = 1'b0;
      settle;
      chk("sb_count", count, 1);
      chk("sb_deferred", mem_en, 0);
`ifdef STORE_BUFFER_FWD_EN
      chk("sb_fwd_hazard", ld_hazard, 0);
      chk("sb_fwd_mask", fwd_mask, 4'b0010);
      chk("sb_fwd_byte", fwd_data[15:8], 8'hAB);
`else
      chk("sb_hazard", ld_hazard, 1);
`endif
      ld_mask = 4'b0001;
      settle;
      chk("sb_other_lane", ld_hazard, 0);
      ld_addr = 32'h208; ld_mask = 4'b0010;
      settle;
      chk("sb_other_word", ld_hazard, 0);
      ld_req = 1'b0; ld_addr = 32'h204;
      settle;
      chk("sb_noreq_hazard", ld_hazard, 0);
      chk("sb_drain_we", mem_we, 4'b0010);
      chk("sb_drain_addr", mem_addr, 32'h204);
      chk("sb_drain_di", mem_di, 32'h0000AB00);
      step; settle;
      chk("sb_empty", empty, 1);

      // byte then halfword to the same word; youngest wins per lane
      ld_req = 1'b1; ld_addr = 32'h900; ld_mask = 4'b1111;
      store(32'h300, 4'b0001, 32'h00000011);
      step;
      store(32'h300, 4'b0011, 32'h00002222);
      step;
      st_valid = 1'b0; ld_addr = 32'h300; ld_mask = 4'b0011;
      settle;
      chk("sh_count", count, 2);
`ifdef STORE_BUFFER_FWD_EN
      chk("sh_fwd_hazard", ld_hazard, 0);
      chk("sh_fwd_data", fwd_data[15:0], 16'h2222);
      chk("sh_fwd_mask", fwd_mask, 4'b0011);
`else
      chk("sh_hazard", ld_hazard, 1);
`endif
      ld_mask = 4'b1111;
      settle;
      chk("sh_word_hazard", ld_hazard, 1);
      ld_addr = 32'h302; ld_mask = 4'b0001;
      settle;
`ifdef STORE_BUFFER_FWD_EN
      chk("sh_lsb_fwd_hazard", ld_hazard, 0);
      chk("sh_lsb_fwd_byte", fwd_data[7:0], 8'h22);
`else
      chk("sh_lsb_hazard", ld_hazard, 1);
`endif
      ld_req = 1'b0;
      settle;
      chk("sh_drain1_di", mem_di, 32'h00000011);
      chk("sh_drain1_we", mem_we, 4'b0001);
      step; settle;
      chk("sh_drain2_di", mem_di, 32'h00002222);
      chk("sh_drain2_we", mem_we, 4'b0011);
      step; settle;
      chk("sh_empty", empty, 1);

      // empty byte-enable stores are dropped; neighbouring word does not match
      store(32'h500, 4'b0000, 32'hFFFFFFFF);
      step;
      st_valid = 1'b0;
      settle;
      chk("web0_count", count, 0);
      chk("web0_no_write", mem_en, 0);
      ld_req = 1'b1; ld_addr = 32'h408; ld_mask = 4'b1111;
      store(32'h400, 4'b1111, 32'h12345678);
      step;
      store(32'h404, 4'b0000, 32'h0);
      step;
      st_valid = 1'b0;
      settle;
      chk("web0_count1", count, 1);
      chk("near_word_hazard", ld_hazard, 0);
`ifdef STORE_BUFFER_FWD_EN
      chk("near_word_fwd_mask", fwd_mask, 4'b0000);
`endif
      ld_req = 1'b0;
      settle;
      chk("near_drain_en", mem_en, 1);
      chk("near_drain_addr", mem_addr, 32'h400);
      step; settle;
      chk("near_empty", empty, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
